red_serial_ctrl: RTL and testbench
==================================

RED_SERIAL_CTRL -- requirements
Module: red_serial_ctrl

Interface
REQ-001 Parameters SHALL be none; the step count is fixed at 7 (constant NUM_STEPS = 7).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a reduction; sampled only when not busy.
REQ-005 flush  input  1  abort any in-flight reduction (pipeline flush).
REQ-006 A  input  16  operand A, captured on accepted start.
REQ-007 B  input  16  operand B, captured on accepted start.
REQ-008 busy  output  1  high while a reduction is in progress (pipeline stall request).
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 S  output  16  reduction result, held until the next done or reset.

Function
REQ-011 Result SHALL equal {6{T[9]}, T[9:0]}, where T = (A[15:8]+B[15:8]) + (A[7:0]+B[7:0]) computed with 9-bit partial sums; T[10+] discarded.
REQ-012 Datapath SHALL use exactly one 4-bit CLA slice, time-shared across 7 steps; no other adders.
REQ-013 Step order: 0: A[11:8]+B[11:8], cin=0 -> P_AB[3:0]; 1: A[15:12]+B[15:12], cin=carry -> P_AB[8:4]; 2: A[3:0]+B[3:0], cin=0 -> P_CD[3:0]; 3: A[7:4]+B[7:4], cin=carry -> P_CD[8:4]; 4: P_AB[3:0]+P_CD[3:0], cin=0; 5: P_AB[7:4]+P_CD[7:4], cin=carry; 6: {3'b0,P_AB[8]}+{3'b0,P_CD[8]}, cin=carry.
REQ-014 Inter-step carry SHALL be registered; steps 0, 2 and 4 force cin=0.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; step counter is 3 bits, 0..6.
REQ-016 IDLE or DONE with start=1 and flush=0 SHALL capture A and B, clear the counter, and go to RUN.
REQ-017 RUN SHALL increment the counter each cycle; at step 6, S SHALL be registered and the FSM SHALL go to DONE.
REQ-018 DONE SHALL last one cycle and return to IDLE unless a new start is accepted (back-to-back allowed).
REQ-019 Latency: start high in cycle 0; busy high in cycles 1-7; done=1 and new S in cycle 8; busy=0 in cycle 8.
REQ-020 busy SHALL be 1 iff state==RUN; done SHALL be 1 iff state==DONE.
REQ-021 start during RUN SHALL be ignored (not queued).
REQ-022 flush SHALL take priority over start and step progress: next state IDLE, no done pulse, S unchanged.
REQ-023 Operands changing during RUN SHALL NOT affect the result.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, counter=0, carry=0, captured operands=0, partials=0, S=16'h0000, busy=0, done=0.
REQ-025 rst SHALL override flush and start; a reset mid-RUN SHALL discard the operation with no done pulse.

Structure
REQ-026 State encodings, NUM_STEPS and the step-index constants SHALL reside in a shared include/package used by this block and its bench.
REQ-027 The existing 4-bit CLA (cla_4bit) SHALL be instantiated once as the only sub-module; its ovfl output is unused.
REQ-028 Operand nibble selection SHALL be a combinational mux indexed by the step counter; all other storage is flops in this module.

Verification
REQ-029 A=16'h0101, B=16'h0101, start pulse -> done in cycle 8, S=16'h0004, busy high for exactly cycles 1-7.
REQ-030 A=16'hFFFF, B=16'hFFFF -> T=10'h3FC, S=16'hFFFC.
REQ-031 A=16'h8080, B=16'h8080 -> T=10'h200, S=16'hFE00 (sign extension from bit 9).
REQ-032 Back-to-back: start again in the done cycle with A=B=16'h0000 -> second done 8 cycles later, S=16'h0000; start pulses at cycles 3-5 ignored.
REQ-033 flush in cycle 4 of a run -> IDLE in cycle 5, no done, S holds the prior value; a rst in cycle 4 of a separate run -> S=16'h0000, no done.
REQ-034 Operands changed every cycle during RUN -> S matches the values captured at start.

Source files
------------

// File: rtl/red_serial_ctrl_pkg.sv
// Shared constants for the serial reduction controller: FSM encoding and step indices.
package red_serial_ctrl_pkg;

  localparam int unsigned NUM_STEPS = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Step indices, in the order the single adder slice is used.
  localparam logic [2:0] StepAbLo  = 3'd0;  // A[11:8]  + B[11:8]
  localparam logic [2:0] StepAbHi  = 3'd1;  // A[15:12] + B[15:12] + carry
  localparam logic [2:0] StepCdLo  = 3'd2;  // A[3:0]   + B[3:0]
  localparam logic [2:0] StepCdHi  = 3'd3;  // A[7:4]   + B[7:4]   + carry
  localparam logic [2:0] StepSumLo = 3'd4;  // P_AB[3:0] + P_CD[3:0]
  localparam logic [2:0] StepSumMd = 3'd5;  // P_AB[7:4] + P_CD[7:4] + carry
  localparam logic [2:0] StepSumHi = 3'd6;  // P_AB[8]   + P_CD[8]   + carry
  localparam logic [2:0] StepLast  = 3'(NUM_STEPS - 1);

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice.
module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic       ovfl_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Generate/propagate terms and flat lookahead carries.
  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c[0] = cin_i;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum_o  = p ^ c[3:0];
    cout_o = c[4];
    ovfl_o = c[3] ^ c[4];
  end

endmodule

// File: rtl/red_serial_ctrl.sv
// Serial reduction: S = sext10((A_hi+B_hi) + (A_lo+B_lo)) using one time-shared 4-bit CLA.
module red_serial_ctrl
  import red_serial_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] S
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [8:0]  pab_q, pab_d;
  logic [8:0]  pcd_q, pcd_d;
  logic [7:0]  tlo_q, tlo_d;
  logic [15:0] s_q, s_d;

  logic [3:0]  op_a, op_b, sum;
  logic        cin, cout;
  logic        cla_ovfl_unused;
  logic        start_ok;

  assign start_ok = start && !flush && (state_q != StRun);

  cla_4bit u_cla (
    .a_i    (op_a),
    .b_i    (op_b),
    .cin_i  (cin),
    .sum_o  (sum),
    .cout_o (cout),
    .ovfl_o (cla_ovfl_unused)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins over start and step progress.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (start) state_d = StRun;
        StRun:   if (cnt_q == StepLast) state_d = StDone;
        StDone:  state_d = start ? StRun : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  assign S = s_q;

  // Operand mux for the shared adder slice, indexed by step.
  always_comb begin
    op_a = 4'h0;
    op_b = 4'h0;
    cin  = 1'b0;
    case (cnt_q)
      StepAbLo:  begin op_a = a_q[11:8];  op_b = b_q[11:8];  end
      StepAbHi:  begin op_a = a_q[15:12]; op_b = b_q[15:12]; cin = carry_q; end
      StepCdLo:  begin op_a = a_q[3:0];   op_b = b_q[3:0];   end
      StepCdHi:  begin op_a = a_q[7:4];   op_b = b_q[7:4];   cin = carry_q; end
      StepSumLo: begin op_a = pab_q[3:0]; op_b = pcd_q[3:0]; end
      StepSumMd: begin op_a = pab_q[7:4]; op_b = pcd_q[7:4]; cin = carry_q; end
      StepSumHi: begin op_a = {3'b000, pab_q[8]}; op_b = {3'b000, pcd_q[8]}; cin = carry_q; end
      default:   ;
    endcase
  end

  // Datapath next-state: operand capture, step accumulation, result commit.
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    pab_d   = pab_q;
    pcd_d   = pcd_q;
    tlo_d   = tlo_q;
    s_d     = s_q;
    if (start_ok) begin
      a_d     = A;
      b_d     = B;
      cnt_d   = 3'd0;
      carry_d = 1'b0;
    end else if (state_q == StRun && !flush) begin
      cnt_d   = (cnt_q == StepLast) ? 3'd0 : cnt_q + 3'd1;
      carry_d = cout;
      case (cnt_q)
        StepAbLo:  pab_d[3:0] = sum;
        StepAbHi:  pab_d[8:4] = {cout, sum};
        StepCdLo:  pcd_d[3:0] = sum;
        StepCdHi:  pcd_d[8:4] = {cout, sum};
        StepSumLo: tlo_d[3:0] = sum;
        StepSumMd: tlo_d[7:4] = sum;
        // T[9:8] come from the last step; T[10+] are dropped.
        StepSumHi: s_d = {{6{sum[1]}}, sum[1:0], tlo_q};
        default:   ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 3'd0;
      carry_q <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      pab_q   <= 9'h000;
      pcd_q   <= 9'h000;
      tlo_q   <= 8'h00;
      s_q     <= 16'h0000;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pab_q   <= pab_d;
      pcd_q   <= pcd_d;
      tlo_q   <= tlo_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: tb/tb_red_serial_ctrl.sv
// Scoreboard bench for red_serial_ctrl: stimulus pushes expected S, monitor checks on done.
module tb_red_serial_ctrl;
  import red_serial_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [15:0] A, B, S;
  logic        busy, done;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  red_serial_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .flush (flush),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got S=%h, expected no done", S);
        end else begin
          e = exp_q.pop_front();
          check("result_S", S, e);
        end
      end
    end
  end

  // Starts a reduction in the current cycle (cycle 0) and returns in the done cycle (cycle 8).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e,
                        input bit pulse, input bit scramble);
    A     = a;
    B     = b;
    start = 1'b1;
    exp_q.push_back(e);
    for (int c = 1; c <= NUM_STEPS; c++) begin
      tick();
      start = pulse && (c >= 3) && (c <= 5);
      if (scramble || pulse) begin
        A = 16'($urandom);
        B = 16'($urandom);
      end
      check("busy_in_run", {15'b0, busy}, 16'h0001);
      check("no_done_in_run", {15'b0, done}, 16'h0000);
    end
    tick();
    start = 1'b0;
    check("busy_at_done", {15'b0, busy}, 16'h0000);
    check("done_pulse", {15'b0, done}, 16'h0001);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; A = 16'h0; B = 16'h0;
    tick();
    tick();
    check("reset_busy", {15'b0, busy}, 16'h0000);
    check("reset_done", {15'b0, done}, 16'h0000);
    check("reset_S", S, 16'h0000);
    rst = 1'b0;
    tick();

    run_op(16'h0101, 16'h0101, 16'h0004, 1'b0, 1'b0);
    tick();
    check("done_one_cycle", {15'b0, done}, 16'h0000);
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFC, 1'b0, 1'b0);
    tick();
    run_op(16'h8080, 16'h8080, 16'hFE00, 1'b0, 1'b0);
    tick();

    // Flush in cycle 4 of a run: back to idle, no done, S keeps FE00.
    A = 16'h1234; B = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    flush = 1'b1;
    check("busy_before_flush", {15'b0, busy}, 16'h0001);
    tick();
    check("flush_busy", {15'b0, busy}, 16'h0000);
    check("flush_done", {15'b0, done}, 16'h0000);
    // Flush also beats a start presented in idle.
    start = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_beats_start", {15'b0, busy}, 16'h0000);
    repeat (9) tick();
    check("flush_no_done", {15'b0, done}, 16'h0000);
    check("flush_S_held", S, 16'hFE00);

    // Operands scrambled every run cycle: 0x12+0x00 + 0x34+0xFF = 0x145.
    run_op(16'h1234, 16'h00FF, 16'h0145, 1'b0, 1'b1);
    tick();

    // Back-to-back with ignored mid-run starts.
    run_op(16'h0101, 16'h0101, 16'h0004, 1'b1, 1'b0);
    run_op(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    check("b2b_end_idle", {15'b0, busy}, 16'h0000);

    run_op(16'h8080, 16'h8080, 16'hFE00, 1'b0, 1'b0);
    tick();

    // Reset in cycle 4 of a run: S cleared, no done.
    A = 16'h0101; B = 16'h0101; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1; start = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    check("rst_run_S", S, 16'h0000);
    check("rst_run_busy", {15'b0, busy}, 16'h0000);
    check("rst_run_done", {15'b0, done}, 16'h0000);
    repeat (9) tick();
    check("rst_no_done", {15'b0, done}, 16'h0000);

    check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
